lsu: RTL and testbench
======================

# lsu

Load/store stage of the in-order core. Accepts one instruction at a time from the EX/LS pipeline register and performs at most one memory access on a req/gnt/rvalid data bus. It formats load data and drives the LS/WB write-back signals consumed directly by the general-purpose register file. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- DATA_LEN, 32, datapath width; only 32 is supported (byte lanes and load formatting are fixed at 4 bytes).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- EX_LS_reg_valid  in  1  upstream instruction valid.
- ls_ready  out  1  stage can accept; an instruction transfers when valid && ready.
- EX_LS_reg_dest_data  in  DATA_LEN  ALU result; the byte address for memory ops.
- EX_LS_reg_store_data  in  DATA_LEN  store source (rs2).
- EX_LS_reg_rd  in  5  destination register.
- EX_LS_reg_dest_wen  in  1  instruction writes rd.
- EX_LS_reg_mem_ren  in  1  load.
- EX_LS_reg_mem_wen  in  1  store; mem_ren and mem_wen are never both 1.
- EX_LS_reg_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_req  out  1  bus request, held until granted.
- mem_we  out  1  1 = write.
- mem_addr  out  DATA_LEN  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  out  DATA_LEN  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0 for reads.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  response (read data or write ack) valid.
- mem_rdata  in  DATA_LEN  read data.
- LS_WB_reg_ls_valid  out  1  one-cycle retire pulse.
- LS_WB_reg_dest_data  out  DATA_LEN  write-back value.
- LS_WB_reg_rd  out  5  write-back register.
- LS_WB_reg_dest_wen  out  1  write-back enable; always 0 for stores.

## Operation
- FSM states: IDLE, REQ, WAIT.
- ls_ready = (state == IDLE).
- IDLE:
  - A non-memory transfer loads the LS_WB outputs from the EX_LS inputs. The FSM stays in IDLE, giving one instruction per cycle.
  - A memory transfer latches addr, size, rd, dest_wen and formatted store data, then moves to REQ.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_wdata and mem_wstrb stay stable until mem_gnt.
  - On mem_gnt, go to WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: load ⇒ LS_WB_reg_dest_data = formatted mem_rdata with dest_wen as latched; store ⇒ dest_wen=0 and dest_data=0.
  - In either case ls_valid pulses next cycle and the FSM returns to IDLE.
- mem_rvalid is ignored outside WAIT. mem_gnt is ignored outside REQ.
- Store formatting:
  - B: wdata = {4{data[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - H: wdata = {2{data[15:0]}}, wstrb = 4'b0011 << {addr[1],1'b0}.
  - W: wdata = data, wstrb = 4'b1111.
- Load formatting:
  - Select the byte at addr[1:0] or the halfword at addr[1].
  - Sign-extend for B/H, zero-extend for BU/HU; W passes through.
- Misalignment is not detected. H ignores addr[0]; W ignores addr[1:0].
- rd = 0 is passed through unchanged; the register file discards x0 writes.

## Timing
- Reset (async): state=IDLE; mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata = 0; all LS_WB_reg_* = 0; ls_ready=1 after release.
- Reset asserted mid-transaction aborts it. A late mem_rvalid after reset release is ignored, because the FSM is in IDLE.
- LS_WB_reg_ls_valid is high for exactly one cycle per retired instruction. It is never high in two consecutive cycles for memory ops, but it can be for back-to-back ALU ops.
- Non-memory latency: transfer at edge N ⇒ ls_valid high during cycle N+1.
- Memory latency:
  - Transfer at edge N; mem_req high from cycle N+1.
  - mem_gnt sampled at edge G moves the FSM to WAIT.
  - mem_rvalid sampled at edge R ≥ G+1 ⇒ ls_valid high in cycle R+1 and ls_ready high in cycle R+1.
  - Minimum load-to-retire is 3 cycles.
- mem_gnt and mem_rvalid in the same cycle: the rvalid is dropped, since the bus never does this.

## Structure
- Shared package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum {IDLE, REQ, WAIT}.
- Sub-module lsu_load_fmt: combinational (rdata, addr[1:0], funct3) → DATA_LEN result.
- Store formatting stays inline.

## Test plan
- ALU pass-through, back-to-back: rd=5 data=0x1234 then rd=6 data=0x5678 on consecutive cycles → ls_valid high in two consecutive cycles with the matching rd/data/wen; ls_ready stays 1.
- LB at addr 0x1003, rdata=0x80FF_FF7F → dest_data=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- LH at addr 0x2002, rdata=0xBEEF_0000 → 0xFFFF_BEEF. LHU → 0x0000_BEEF. LW → rdata unchanged.
- SB at addr 0x3001, data 0xAB, gnt delayed 3 cycles → mem_req held with wdata=0xABABABAB and wstrb=0010; after rvalid, ls_valid pulses with dest_wen=0.
- rst_n asserted while in WAIT, then a stray mem_rvalid after release → all outputs 0, no ls_valid pulse, ls_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 size codes and FSM state type for the load/store stage.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/lsu_load_fmt.sv
// lsu_load_fmt: selects and sign/zero-extends the addressed byte or halfword of a read word.
module lsu_load_fmt
    import lsu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic [DATA_LEN-1:0] rdata,
    input  logic [1:0]          addr,
    input  logic [2:0]          funct3,
    output logic [DATA_LEN-1:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[{addr, 3'b000} +: 8];
    assign h = addr[1] ? rdata[31:16] : rdata[15:0];
    assign result = funct3 == F3_B  ? {{24{b[7]}}, b} :
                    funct3 == F3_BU ? {24'd0, b} :
                    funct3 == F3_H  ? {{16{h[15]}}, h} :
                    funct3 == F3_HU ? {16'd0, h} : rdata;
endmodule

// File: rtl/lsu.sv
// lsu: load/store stage; one req/gnt/rvalid bus access per memory op, ALU ops pass through in one cycle.
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                EX_LS_reg_valid,
    output logic                ls_ready,
    input  logic [DATA_LEN-1:0] EX_LS_reg_dest_data,
    input  logic [DATA_LEN-1:0] EX_LS_reg_store_data,
    input  logic [4:0]          EX_LS_reg_rd,
    input  logic                EX_LS_reg_dest_wen,
    input  logic                EX_LS_reg_mem_ren,
    input  logic                EX_LS_reg_mem_wen,
    input  logic [2:0]          EX_LS_reg_funct3,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                LS_WB_reg_ls_valid,
    output logic [DATA_LEN-1:0] LS_WB_reg_dest_data,
    output logic [4:0]          LS_WB_reg_rd,
    output logic                LS_WB_reg_dest_wen
);
    state_t state, state_nxt;
    logic fire, is_mem, load_q, wen_q, done;
    logic [1:0] off_q, a;
    logic [2:0] f3_q, f3;
    logic [4:0] rd_q;
    logic [DATA_LEN-1:0] sd, st_wdata, ld_data;
    logic [3:0] st_wstrb;

    assign ls_ready = state == IDLE;
    assign mem_req  = state == REQ;
    assign fire     = EX_LS_reg_valid && ls_ready;
    assign is_mem   = EX_LS_reg_mem_ren || EX_LS_reg_mem_wen;
    assign done     = state == WAIT && mem_rvalid;
    assign sd       = EX_LS_reg_store_data;
    assign a        = EX_LS_reg_dest_data[1:0];
    assign f3       = EX_LS_reg_funct3;
    assign st_wdata = f3[1] ? sd : f3[0] ? {2{sd[15:0]}} : {4{sd[7:0]}};
    assign st_wstrb = f3[1] ? 4'b1111 : f3[0] ? 4'b0011 << {a[1], 1'b0} : 4'b0001 << a;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = fire && is_mem ? REQ : IDLE;
            REQ:     state_nxt = mem_gnt ? WAIT : REQ;
            default: state_nxt = mem_rvalid ? IDLE : WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    lsu_load_fmt #(.DATA_LEN(DATA_LEN)) u_fmt (
        .rdata  (mem_rdata),
        .addr   (off_q),
        .funct3 (f3_q),
        .result (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we              <= 1'b0;
            mem_addr            <= '0;
            mem_wdata           <= '0;
            mem_wstrb           <= '0;
            off_q               <= '0;
            f3_q                <= '0;
            rd_q                <= '0;
            wen_q               <= 1'b0;
            load_q              <= 1'b0;
            LS_WB_reg_ls_valid  <= 1'b0;
            LS_WB_reg_dest_data <= '0;
            LS_WB_reg_rd        <= '0;
            LS_WB_reg_dest_wen  <= 1'b0;
        end else begin
            LS_WB_reg_ls_valid <= 1'b0;
            if (fire && !is_mem) begin
                LS_WB_reg_ls_valid  <= 1'b1;
                LS_WB_reg_dest_data <= EX_LS_reg_dest_data;
                LS_WB_reg_rd        <= EX_LS_reg_rd;
                LS_WB_reg_dest_wen  <= EX_LS_reg_dest_wen;
            end
            if (fire && is_mem) begin
                mem_we    <= EX_LS_reg_mem_wen;
                mem_addr  <= {EX_LS_reg_dest_data[DATA_LEN-1:2], 2'b00};
                mem_wdata <= st_wdata;
                mem_wstrb <= EX_LS_reg_mem_wen ? st_wstrb : 4'b0000;
                off_q     <= a;
                f3_q      <= f3;
                rd_q      <= EX_LS_reg_rd;
                wen_q     <= EX_LS_reg_dest_wen;
                load_q    <= EX_LS_reg_mem_ren;
            end
            // stores retire with no register write
            if (done) begin
                LS_WB_reg_ls_valid  <= 1'b1;
                LS_WB_reg_dest_data <= load_q ? ld_data : '0;
                LS_WB_reg_rd        <= rd_q;
                LS_WB_reg_dest_wen  <= load_q && wen_q;
            end
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven checks of ALU pass-through, load/store formatting, stalled grant and reset abort.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready, dwen, ren, wen;
    logic [31:0] ddata, sdata, mem_addr, mem_wdata, mem_rdata, wb_data;
    logic [4:0]  rd, wb_rd;
    logic [2:0]  f3;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, wb_valid, wb_wen;
    logic [3:0]  mem_wstrb;
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    lsu #(.DATA_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .EX_LS_reg_valid(valid), .ls_ready(ready),
        .EX_LS_reg_dest_data(ddata), .EX_LS_reg_store_data(sdata), .EX_LS_reg_rd(rd),
        .EX_LS_reg_dest_wen(dwen), .EX_LS_reg_mem_ren(ren), .EX_LS_reg_mem_wen(wen),
        .EX_LS_reg_funct3(f3), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .LS_WB_reg_ls_valid(wb_valid), .LS_WB_reg_dest_data(wb_data),
        .LS_WB_reg_rd(wb_rd), .LS_WB_reg_dest_wen(wb_wen)
    );

    typedef struct {
        logic        ren, wen;
        logic [2:0]  f3;
        logic [31:0] addr, sdata;
        logic [4:0]  rd;
        logic        dwen;
        logic [31:0] rdata, exp_data, exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        exp_wen;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        valid = 1'b1; ren = v.ren; wen = v.wen; f3 = v.f3; ddata = v.addr;
        sdata = v.sdata; rd = v.rd; dwen = v.dwen;
    endtask

    task automatic idle_in;
        valid = 1'b0; ren = 1'b0; wen = 1'b0;
    endtask

    vec_t vt[10];

    initial begin
        rst_n = 1'b0; idle_in; f3 = 3'b0; ddata = '0; sdata = '0; rd = '0; dwen = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step; step;
        chk("rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        rst_n = 1'b1;
        step;
        chk("rst_ready", {31'd0, ready}, 32'd1);

        //          ren   wen   f3      addr          sdata         rd     dwen  rdata         exp_data      exp_wdata     wstrb    exp_wen
        vt[0] = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        5'd5,  1'b1, 32'h0,        32'h0000_1234, 32'h0,       4'b0000, 1'b1};
        vt[1] = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        5'd7,  1'b1, 32'h80FF_FF7F, 32'hFFFF_FF80, 32'h0,       4'b0000, 1'b1};
        vt[2] = '{1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0,        5'd8,  1'b1, 32'h80FF_FF7F, 32'h0000_0080, 32'h0,       4'b0000, 1'b1};
        vt[3] = '{1'b1, 1'b0, 3'b000, 32'h0000_1000, 32'h0,        5'd9,  1'b1, 32'h80FF_FF7F, 32'h0000_007F, 32'h0,       4'b0000, 1'b1};
        vt[4] = '{1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0,        5'd10, 1'b1, 32'hBEEF_0000, 32'hFFFF_BEEF, 32'h0,       4'b0000, 1'b1};
        vt[5] = '{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,        5'd11, 1'b1, 32'hBEEF_0000, 32'h0000_BEEF, 32'h0,       4'b0000, 1'b1};
        vt[6] = '{1'b1, 1'b0, 3'b010, 32'h0000_2002, 32'h0,        5'd12, 1'b1, 32'hBEEF_0000, 32'hBEEF_0000, 32'h0,       4'b0000, 1'b1};
        vt[7] = '{1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 5'd13, 1'b1, 32'h0,        32'h0,        32'hDEAD_BEEF, 4'b1111, 1'b0};
        vt[8] = '{1'b0, 1'b1, 3'b001, 32'h0000_5002, 32'h1234_CAFE, 5'd14, 1'b0, 32'h0,        32'h0,        32'hCAFE_CAFE, 4'b1100, 1'b0};
        vt[9] = '{1'b1, 1'b0, 3'b000, 32'h0000_1001, 32'h0,        5'd0,  1'b1, 32'h80FF_FF7F, 32'hFFFF_FFFF, 32'h0,       4'b0000, 1'b1};

        for (int i = 0; i < 10; i++) begin
            drive(vt[i]);
            step;
            idle_in;
            if (vt[i].ren || vt[i].wen) begin
                chk($sformatf("v%0d_req", i), {31'd0, mem_req}, 32'd1);
                chk($sformatf("v%0d_ready", i), {31'd0, ready}, 32'd0);
                chk($sformatf("v%0d_addr", i), mem_addr, {vt[i].addr[31:2], 2'b00});
                chk($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, vt[i].wen});
                chk($sformatf("v%0d_wstrb", i), {28'd0, mem_wstrb}, {28'd0, vt[i].exp_wstrb});
                if (vt[i].wen) chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].exp_wdata);
                mem_gnt = 1'b1;
                step;
                mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = vt[i].rdata;
                chk($sformatf("v%0d_req_wait", i), {31'd0, mem_req}, 32'd0);
                step;
                mem_rvalid = 1'b0; mem_rdata = '0;
            end
            chk($sformatf("v%0d_valid", i), {31'd0, wb_valid}, 32'd1);
            chk($sformatf("v%0d_data", i), wb_data, vt[i].exp_data);
            chk($sformatf("v%0d_rd", i), {27'd0, wb_rd}, {27'd0, vt[i].rd});
            chk($sformatf("v%0d_wen", i), {31'd0, wb_wen}, {31'd0, vt[i].exp_wen});
            chk($sformatf("v%0d_ready_after", i), {31'd0, ready}, 32'd1);
            step;
            chk($sformatf("v%0d_pulse_end", i), {31'd0, wb_valid}, 32'd0);
        end

        // back-to-back ALU ops retire on consecutive cycles
        drive(vt[0]);
        step;
        vt[0].addr = 32'h0000_5678; vt[0].rd = 5'd6; vt[0].dwen = 1'b0;
        drive(vt[0]);
        chk("b2b_valid0", {31'd0, wb_valid}, 32'd1);
        chk("b2b_rd0", {27'd0, wb_rd}, 32'd5);
        chk("b2b_data0", wb_data, 32'h0000_1234);
        chk("b2b_ready0", {31'd0, ready}, 32'd1);
        step;
        idle_in;
        chk("b2b_valid1", {31'd0, wb_valid}, 32'd1);
        chk("b2b_rd1", {27'd0, wb_rd}, 32'd6);
        chk("b2b_data1", wb_data, 32'h0000_5678);
        chk("b2b_wen1", {31'd0, wb_wen}, 32'd0);
        step;
        chk("b2b_end", {31'd0, wb_valid}, 32'd0);

        // SB with grant held off for three cycles; bus fields must stay stable
        valid = 1'b1; ren = 1'b0; wen = 1'b1; f3 = 3'b000; ddata = 32'h0000_3001;
        sdata = 32'h1234_56AB; rd = 5'd3; dwen = 1'b1;
        step;
        idle_in;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("sb_req%0d", c), {31'd0, mem_req}, 32'd1);
            chk($sformatf("sb_wdata%0d", c), mem_wdata, 32'hABAB_ABAB);
            chk($sformatf("sb_wstrb%0d", c), {28'd0, mem_wstrb}, 32'h2);
            chk($sformatf("sb_addr%0d", c), mem_addr, 32'h0000_3000);
            mem_rvalid = (c == 1);
            step;
            mem_rvalid = 1'b0;
            chk($sformatf("sb_novalid%0d", c), {31'd0, wb_valid}, 32'd0);
        end
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        chk("sb_req_drop", {31'd0, mem_req}, 32'd0);
        step;
        chk("sb_wait_novalid", {31'd0, wb_valid}, 32'd0);
        chk("sb_wait_ready", {31'd0, ready}, 32'd0);
        mem_rvalid = 1'b1;
        step;
        mem_rvalid = 1'b0;
        chk("sb_valid", {31'd0, wb_valid}, 32'd1);
        chk("sb_wen", {31'd0, wb_wen}, 32'd0);
        chk("sb_data", wb_data, 32'd0);
        chk("sb_rd", {27'd0, wb_rd}, 32'd3);

        // reset during WAIT, then a stray rvalid after release
        drive(vt[1]);
        step;
        idle_in;
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_req", {31'd0, mem_req}, 32'd0);
        chk("ar_data", wb_data, 32'd0);
        chk("ar_addr", mem_addr, 32'd0);
        step;
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step;
        mem_rvalid = 1'b0;
        chk("ar_novalid", {31'd0, wb_valid}, 32'd0);
        chk("ar_ready", {31'd0, ready}, 32'd1);
        chk("ar_wen", {31'd0, wb_wen}, 32'd0);
        chk("ar_rd", {27'd0, wb_rd}, 32'd0);
        chk("ar_wb_data", wb_data, 32'd0);
        chk("ar_req_after", {31'd0, mem_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
